// File: rtl/row_replay_reader.sv
// Captures one pixel row, then replays it as a nearest-neighbour upscaled stream:
// each pixel is repeated SCALE times horizontally and the whole row SCALE times vertically.
//   state  | meaning
//   FILL   | accepting input pixels into the row store
//   REPLAY | streaming the stored row out, SCALE x SCALE upscaled
module row_replay_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_WIDTH  = 128,
    parameter int SCALE      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(SCALE - 1);

    typedef enum logic {FILL, REPLAY} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         wr_col;
    logic [CW-1:0]         rd_col;
    logic [RW-1:0]         h_rep;
    logic [RW-1:0]         v_rep;
    logic [DATA_WIDTH-1:0] store [IMG_WIDTH];
    logic                  accept;
    logic                  emit;
    logic                  wr_end;
    logic                  col_end;
    logic                  h_end;
    logic                  v_end;

    // s_ready and m_valid already carry ce, the extra term keeps the intent explicit
    assign accept  = s_valid & s_ready & ce;
    assign emit    = m_valid & m_ready & ce;
    assign wr_end  = (wr_col == COL_LAST);
    assign col_end = (rd_col == COL_LAST);
    assign h_end   = (h_rep == REP_LAST);
    assign v_end   = (v_rep == REP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept && wr_end) begin
                    state_next = REPLAY;
                end
            end
            REPLAY: begin
                if (emit && col_end && h_end && v_end) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_done  = 1'b0;
        case (state)
            FILL: begin
                s_ready = ce & ~rst;
            end
            REPLAY: begin
                m_valid = ce;
                m_data  = store[rd_col];
                m_last  = col_end & h_end;
                m_done  = col_end & h_end & v_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_col <= '0;
            rd_col <= '0;
            h_rep  <= '0;
            v_rep  <= '0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (accept) begin
                store[wr_col] <= s_data;
                wr_col        <= wr_end ? '0 : wr_col + CW'(1);
            end
            // h_rep is the innermost loop, then column, then vertical repeat
            if (emit) begin
                if (!h_end) begin
                    h_rep <= h_rep + RW'(1);
                end else begin
                    h_rep <= '0;
                    if (!col_end) begin
                        rd_col <= rd_col + CW'(1);
                    end else begin
                        rd_col <= '0;
                        v_rep  <= v_end ? '0 : v_rep + RW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_row_replay_reader.sv
// Directed bench for row_replay_reader with DATA_WIDTH=8, IMG_WIDTH=4, SCALE=2.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
module tb_row_replay_reader;
    logic       clk;
    logic       rst;
    logic       ce;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_done;

    int n_cmp;
    int n_err;

    logic [7:0] cap_data [64];
    logic       cap_last [64];
    logic       cap_done [64];
    int         cap_n;
    int         cap_cycles;
    int         stall_chg;
    int         sready_hi;
    bit         feed_to;
    int         fill_mv;

    row_replay_reader #(
        .DATA_WIDTH(8),
        .IMG_WIDTH (4),
        .SCALE     (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last (m_last),
        .m_done (m_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pixel k of a 16-pixel replay: two copies of each pixel, row repeated twice
    function automatic logic [7:0] exp_pix(input logic [31:0] r, input int k);
        int col;
        col = (k % 8) / 2;
        return r[8*col +: 8];
    endfunction

    task automatic feed(input logic [31:0] r, input int gap_len, input bit hold);
        int waitc;
        feed_to = 1'b0;
        fill_mv = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap_len; g++) begin
                    s_valid = 1'b0;
                    #1;
                    if (m_valid) fill_mv++;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = r[8*i +: 8];
            waitc   = 0;
            #1;
            while (!s_ready && waitc < 200) begin
                @(posedge clk); #1;
                waitc++;
            end
            if (!s_ready) feed_to = 1'b1;
            if (m_valid) fill_mv++;
            @(posedge clk); #1;
        end
        if (!hold) s_valid = 1'b0;
    endtask

    // mode 0: m_ready held high; mode 1: m_ready toggles 1,0,1,0 per cycle
    task automatic drain(input int n, input int mode, input int budget);
        int         cyc;
        logic [7:0] held;
        bit         holding;
        cap_n     = 0;
        stall_chg = 0;
        sready_hi = 0;
        holding   = 1'b0;
        held      = '0;
        cyc       = 0;
        while (cap_n < n && cyc < budget) begin
            m_ready = (mode == 1) ? ~cyc[0] : 1'b1;
            #1;
            if (s_ready) sready_hi++;
            if (m_valid) begin
                if (holding && m_data !== held) stall_chg++;
                if (m_ready) begin
                    cap_data[cap_n] = m_data;
                    cap_last[cap_n] = m_last;
                    cap_done[cap_n] = m_done;
                    cap_n++;
                    holding = 1'b0;
                end else begin
                    held    = m_data;
                    holding = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        cap_cycles = cyc;
        m_ready    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        #2;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        n_cmp++; if ({m_last, m_done} !== 2'b00) begin n_err++; $display("FAIL reset_last_done: got %b want 00", {m_last, m_done}); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_s_ready: got %b want 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] r;
        r = 32'h44332211;
        feed(r, 0, 1'b0);
        n_cmp++; if (feed_to !== 1'b0) begin n_err++; $display("FAIL basic_feed_timeout: got %b want 0", feed_to); end
        n_cmp++; if (fill_mv !== 0) begin n_err++; $display("FAIL basic_fill_m_valid: got %0d want 0", fill_mv); end
        drain(16, 0, 100);
        n_cmp++; if (cap_n !== 16) begin n_err++; $display("FAIL basic_count: got %0d want 16", cap_n); end
        n_cmp++; if (cap_cycles !== 16) begin n_err++; $display("FAIL basic_cycles: got %0d want 16", cap_cycles); end
        n_cmp++; if (sready_hi !== 0) begin n_err++; $display("FAIL basic_s_ready_in_replay: got %0d want 0", sready_hi); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r, k)) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r, k)); end
            n_cmp++; if ({cap_last[k], cap_done[k]} !== {(k % 8) == 7, k == 15}) begin n_err++; $display("FAIL basic_last_done[%0d]: got %b%b want %b%b", k, cap_last[k], cap_done[k], (k % 8) == 7, k == 15); end
        end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL basic_turnaround_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] r;
        r = 32'h88776655;
        feed(r, 0, 1'b0);
        n_cmp++; if (feed_to !== 1'b0) begin n_err++; $display("FAIL bp_feed_timeout: got %b want 0", feed_to); end
        drain(16, 1, 100);
        n_cmp++; if (cap_n !== 16) begin n_err++; $display("FAIL bp_count: got %0d want 16", cap_n); end
        n_cmp++; if (cap_cycles !== 31) begin n_err++; $display("FAIL bp_cycles: got %0d want 31", cap_cycles); end
        n_cmp++; if (stall_chg !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_chg); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r, k)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r, k)); end
            n_cmp++; if ({cap_last[k], cap_done[k]} !== {(k % 8) == 7, k == 15}) begin n_err++; $display("FAIL bp_last_done[%0d]: got %b%b want %b%b", k, cap_last[k], cap_done[k], (k % 8) == 7, k == 15); end
        end
    endtask

    task automatic test_input_gaps();
        logic [31:0] r;
        r = 32'h44332211;
        feed(r, 3, 1'b0);
        n_cmp++; if (feed_to !== 1'b0) begin n_err++; $display("FAIL gap_feed_timeout: got %b want 0", feed_to); end
        n_cmp++; if (fill_mv !== 0) begin n_err++; $display("FAIL gap_fill_m_valid: got %0d want 0", fill_mv); end
        drain(16, 0, 100);
        n_cmp++; if (cap_cycles !== 16) begin n_err++; $display("FAIL gap_cycles: got %0d want 16", cap_cycles); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r, k)) begin n_err++; $display("FAIL gap_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r, k)); end
        end
    endtask

    task automatic test_reset_mid_replay();
        logic [31:0] r;
        r = 32'h9C9B9A99;
        feed(r, 0, 1'b0);
        drain(10, 0, 100);
        n_cmp++; if (cap_n !== 10) begin n_err++; $display("FAIL rstmid_pre_count: got %0d want 10", cap_n); end
        rst = 1'b1;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_s_ready_in_reset: got %b want 0", s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_s_ready_release: got %b want 1", s_ready); end
        @(posedge clk); #1;
        r = 32'hA3A2A1A0;
        feed(r, 0, 1'b0);
        drain(16, 0, 100);
        n_cmp++; if (cap_cycles !== 16) begin n_err++; $display("FAIL rstmid_cycles: got %0d want 16", cap_cycles); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r, k)) begin n_err++; $display("FAIL rstmid_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r, k)); end
            n_cmp++; if ({cap_last[k], cap_done[k]} !== {(k % 8) == 7, k == 15}) begin n_err++; $display("FAIL rstmid_last_done[%0d]: got %b%b want %b%b", k, cap_last[k], cap_done[k], (k % 8) == 7, k == 15); end
        end
    endtask

    task automatic test_ce_gating();
        logic [31:0] r;
        int          first_n;
        int          mv_hi;
        r = 32'h44332211;
        feed(r, 0, 1'b0);
        drain(6, 0, 100);
        first_n = cap_n;
        mv_hi   = 0;
        ce      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (m_valid) mv_hi++;
            @(posedge clk); #1;
        end
        ce = 1'b1;
        n_cmp++; if (mv_hi !== 0) begin n_err++; $display("FAIL ce_m_valid_low: got %0d cycles high want 0", mv_hi); end
        drain(10, 0, 100);
        n_cmp++; if (first_n + cap_n !== 16) begin n_err++; $display("FAIL ce_total_emits: got %0d want 16", first_n + cap_n); end
        n_cmp++; if (cap_data[0] !== 8'h44) begin n_err++; $display("FAIL ce_resume_pixel: got %h want 44", cap_data[0]); end
        for (int k = 0; k < 10; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r, k + 6)) begin n_err++; $display("FAIL ce_data[%0d]: got %h want %h", k + 6, cap_data[k], exp_pix(r, k + 6)); end
            n_cmp++; if ({cap_last[k], cap_done[k]} !== {((k + 6) % 8) == 7, (k + 6) == 15}) begin n_err++; $display("FAIL ce_last_done[%0d]: got %b%b", k + 6, cap_last[k], cap_done[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = 32'hB3B2B1B0;
        r2 = 32'hD3D2D1D0;
        feed(r1, 0, 1'b1);
        s_data = r2[7:0];
        drain(16, 0, 100);
        n_cmp++; if (sready_hi !== 0) begin n_err++; $display("FAIL b2b_early_accept: got %0d s_ready cycles want 0", sready_hi); end
        n_cmp++; if (cap_cycles !== 16) begin n_err++; $display("FAIL b2b_row1_cycles: got %0d want 16", cap_cycles); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r1, k)) begin n_err++; $display("FAIL b2b_row1_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r1, k)); end
        end
        feed(r2, 0, 1'b0);
        n_cmp++; if (feed_to !== 1'b0) begin n_err++; $display("FAIL b2b_feed_timeout: got %b want 0", feed_to); end
        drain(16, 0, 100);
        n_cmp++; if (cap_n !== 16) begin n_err++; $display("FAIL b2b_row2_count: got %0d want 16", cap_n); end
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (cap_data[k] !== exp_pix(r2, k)) begin n_err++; $display("FAIL b2b_row2_data[%0d]: got %h want %h", k, cap_data[k], exp_pix(r2, k)); end
            n_cmp++; if ({cap_last[k], cap_done[k]} !== {(k % 8) == 7, k == 15}) begin n_err++; $display("FAIL b2b_row2_last_done[%0d]: got %b%b want %b%b", k, cap_last[k], cap_done[k], (k % 8) == 7, k == 15); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_input_gaps();
        test_reset_mid_replay();
        test_ce_gating();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/row_replay_reader.md
Name: row_replay_reader

Overview:
- Output-side counterpart to the row line buffer. The line buffer writes pixel rows in; this block reads a captured row back out.
- Accepts one input row over a valid/ready stream into an internal row store. It then replays the row as a nearest-neighbour upscaled stream: each pixel is repeated SCALE times horizontally, and the whole row is repeated SCALE times vertically.
- Sits between the pixel source / line-buffer pipeline and the output frame writer of the image upscaler.

Parameters:
- DATA_WIDTH, 24, pixel width in bits (packed RGB).
- IMG_WIDTH, 128, input pixels per row; must be ≥ 2.
- SCALE, 2, integer upscale factor per axis; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable; when low, all state is frozen.
- s_data  input  DATA_WIDTH  input pixel.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block can accept an input pixel.
- m_data  output  DATA_WIDTH  replayed output pixel.
- m_valid  output  1  output pixel valid.
- m_ready  input  1  downstream accepts m_data.
- m_last  output  1  last pixel of the current output row.
- m_done  output  1  last pixel of the final replayed row.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=FILL; wr_col, rd_col, h_rep, v_rep = 0.
  - Row store cleared to 0.
  - s_ready=0 while rst is asserted; m_valid=0, m_data=0, m_last=0, m_done=0.
- Counter widths: $clog2(IMG_WIDTH) for the column counters, $clog2(SCALE) (minimum 1 bit) for the repeat counters.
- Accept event: s_valid & s_ready & ce. Emit event: m_valid & m_ready & ce.
- ce=0: no counter, store or state update. s_ready and m_valid are driven 0 so no transfer occurs.
- State FILL:
  - s_ready=ce; m_valid=0.
  - On accept: store[wr_col] <= s_data; wr_col increments.
  - On accept with wr_col==IMG_WIDTH-1: wr_col <= 0; state <= REPLAY.
- State REPLAY:
  - s_ready=0; m_valid=ce.
  - m_data = store[rd_col], read combinationally from the registered store.
  - Output order: for v_rep = 0..SCALE-1, for rd_col = 0..IMG_WIDTH-1, for h_rep = 0..SCALE-1, emit store[rd_col].
  - On emit:
    - If h_rep < SCALE-1: h_rep++.
    - Else h_rep <= 0. Then, if rd_col < IMG_WIDTH-1: rd_col++.
    - Else rd_col <= 0. Then, if v_rep < SCALE-1: v_rep++.
    - Else v_rep <= 0 and state <= FILL.
  - m_last = REPLAY & rd_col==IMG_WIDTH-1 & h_rep==SCALE-1 (combinational, independent of m_ready).
  - m_done = m_last & v_rep==SCALE-1.
- Latency: first m_valid occurs in the cycle after the accept of the last input pixel.
- Throughput and back-pressure:
  - Input phase takes IMG_WIDTH accepts; output phase takes SCALE*SCALE*IMG_WIDTH emits.
  - m_data, m_last and m_done are held stable while m_valid=1 & m_ready=0.
- Turnaround: s_ready rises in the cycle after the m_done emit. There are no simultaneous accept and emit; this is a single-buffer design with no ping-pong.
- SCALE=1: the block degenerates to a 1-row store-and-forward; m_last=m_done on every row end.
- Reset mid-replay: output stream aborts immediately, m_valid=0, and the next row refills from column 0.
- Partial input row when reset asserts: discarded.

Test Plan (bench params DATA_WIDTH=8, IMG_WIDTH=4, SCALE=2):
- Basic: feed 0x11,0x22,0x33,0x44 with m_ready=1.
  - Required output: 11,11,22,22,33,33,44,44, then the same 8 pixels again.
  - m_last on outputs 8 and 16; m_done on output 16 only.
  - s_ready=0 for those 16 cycles, then returns to 1.
- Back-pressure: as Basic but m_ready toggles 1,0,1,0.
  - Same 16-pixel sequence; m_data stable during each stall; no pixel duplicated or dropped.
- Input gaps: s_valid low for 3 cycles between pixels 2 and 3.
  - Store still holds 0x11,0x22,0x33,0x44; replay starts exactly 1 cycle after the 4th accept.
- ce gating: drop ce for 5 cycles mid-replay (after output 6).
  - m_valid=0 throughout; resumes at output 7 = 0x44; total emits = 16.
- Reset mid-replay: assert rst after output 10.
  - m_valid=0 the same cycle; s_ready=1 after release; next row 0xA0..0xA3 replays as A0,A0,A1,A1,... with no stale data.
- Back-to-back rows: two rows supplied with s_valid held high.
  - Second row accepted only after the first m_done; outputs are 32 pixels in correct order.
